// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// reservation_station : out-of-order ALU/branch issue buffer with operand
//                       wakeup from ALU/LSB broadcasts; one dispatch per cycle
// Revision 1.0
// ============================================================================
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int RS_LOG  = 4,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               ISS_valid,
  input  logic [OP_LOG-1:0]  ISS_op,
  input  logic [31:0]        ISS_Vj,
  input  logic [31:0]        ISS_Vk,
  input  logic               ISS_Rj,
  input  logic               ISS_Rk,
  input  logic [ROB_LOG-1:0] ISS_Qj,
  input  logic [ROB_LOG-1:0] ISS_Qk,
  input  logic [31:0]        ISS_Imm,
  input  logic [ROB_LOG-1:0] ISS_DestRob,
  input  logic [31:0]        ISS_CurPC,
  input  logic               ALU_enable,
  input  logic [ROB_LOG-1:0] ALU_RobId,
  input  logic [31:0]        ALU_value,
  input  logic               LSB_enable,
  input  logic [ROB_LOG-1:0] LSB_RobId,
  input  logic [31:0]        LSB_value,
  output logic               RS_full,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [ROB_LOG-1:0] RS_DestRob,
  output logic [31:0]        RS_CurPC
);

  localparam logic [OP_LOG-1:0] C_OP_NOP = '0;

  logic [RS_SIZE-1:0] r_busy, r_rj, r_rk;
  logic [OP_LOG-1:0]  r_op   [RS_SIZE];
  logic [31:0]        r_vj   [RS_SIZE];
  logic [31:0]        r_vk   [RS_SIZE];
  logic [31:0]        r_imm  [RS_SIZE];
  logic [31:0]        r_pc   [RS_SIZE];
  logic [ROB_LOG-1:0] r_qj   [RS_SIZE];
  logic [ROB_LOG-1:0] r_qk   [RS_SIZE];
  logic [ROB_LOG-1:0] r_dest [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic               w_ready_found;
  logic [RS_LOG-1:0]  w_ready_idx, w_free_idx;
  logic               w_issue;
  logic [31:0]        w_iss_vj, w_iss_vk;
  logic               w_iss_rj, w_iss_rk;

  assign RS_full = &r_busy;
  assign w_ready = r_busy & ~r_rj & ~r_rk;
  assign w_issue = ISS_valid && !RS_full && (ISS_op != C_OP_NOP);

  // Descending scan so the lowest index is the last one to win.
  always_comb begin
    w_ready_found = 1'b0;
    w_ready_idx   = '0;
    w_free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_ready_found = 1'b1;
        w_ready_idx   = RS_LOG'(i);
      end
      if (!r_busy[i]) begin
        w_free_idx = RS_LOG'(i);
      end
    end
  end

  // Capture a broadcast that lands in the same cycle as the issue.
  always_comb begin
    w_iss_vj = ISS_Vj;
    w_iss_rj = ISS_Rj;
    w_iss_vk = ISS_Vk;
    w_iss_rk = ISS_Rk;
    if (ISS_Rj && ALU_enable && ALU_RobId == ISS_Qj) begin
      w_iss_vj = ALU_value;
      w_iss_rj = 1'b0;
    end else if (ISS_Rj && LSB_enable && LSB_RobId == ISS_Qj) begin
      w_iss_vj = LSB_value;
      w_iss_rj = 1'b0;
    end
    if (ISS_Rk && ALU_enable && ALU_RobId == ISS_Qk) begin
      w_iss_vk = ALU_value;
      w_iss_rk = 1'b0;
    end else if (ISS_Rk && LSB_enable && LSB_RobId == ISS_Qk) begin
      w_iss_vk = LSB_value;
      w_iss_rk = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_rj       <= '0;
      r_rk       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]   <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_dest[i] <= '0;
      end
      RS_valid   <= 1'b0;
      RS_op      <= '0;
      RS_Vj      <= '0;
      RS_Vk      <= '0;
      RS_Imm     <= '0;
      RS_DestRob <= '0;
      RS_CurPC   <= '0;
    end else if (rdy) begin
      if (clear) begin
        r_busy   <= '0;
        RS_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_rj[i]) begin
            if (ALU_enable && ALU_RobId == r_qj[i]) begin
              r_vj[i] <= ALU_value;
              r_rj[i] <= 1'b0;
            end else if (LSB_enable && LSB_RobId == r_qj[i]) begin
              r_vj[i] <= LSB_value;
              r_rj[i] <= 1'b0;
            end
          end
          if (r_busy[i] && r_rk[i]) begin
            if (ALU_enable && ALU_RobId == r_qk[i]) begin
              r_vk[i] <= ALU_value;
              r_rk[i] <= 1'b0;
            end else if (LSB_enable && LSB_RobId == r_qk[i]) begin
              r_vk[i] <= LSB_value;
              r_rk[i] <= 1'b0;
            end
          end
        end

        if (w_ready_found) begin
          RS_valid            <= 1'b1;
          RS_op               <= r_op[w_ready_idx];
          RS_Vj               <= r_vj[w_ready_idx];
          RS_Vk               <= r_vk[w_ready_idx];
          RS_Imm              <= r_imm[w_ready_idx];
          RS_DestRob          <= r_dest[w_ready_idx];
          RS_CurPC            <= r_pc[w_ready_idx];
          r_busy[w_ready_idx] <= 1'b0;
        end else begin
          RS_valid <= 1'b0;
        end

        // The free slot is never the dispatched one, so these writes cannot collide.
        if (w_issue) begin
          r_busy[w_free_idx] <= 1'b1;
          r_op[w_free_idx]   <= ISS_op;
          r_vj[w_free_idx]   <= w_iss_vj;
          r_rj[w_free_idx]   <= w_iss_rj;
          r_qj[w_free_idx]   <= ISS_Qj;
          r_vk[w_free_idx]   <= w_iss_vk;
          r_rk[w_free_idx]   <= w_iss_rk;
          r_qk[w_free_idx]   <= ISS_Qk;
          r_imm[w_free_idx]  <= ISS_Imm;
          r_dest[w_free_idx] <= ISS_DestRob;
          r_pc[w_free_idx]   <= ISS_CurPC;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// tb_reservation_station : vector table + scoreboard bench for reservation_station
// Revision 1.0
// ============================================================================
module tb_reservation_station;

  logic        clk, rst, rdy, clear;
  logic        ISS_valid, ISS_Rj, ISS_Rk;
  logic [5:0]  ISS_op;
  logic [31:0] ISS_Vj, ISS_Vk, ISS_Imm, ISS_CurPC;
  logic [3:0]  ISS_Qj, ISS_Qk, ISS_DestRob;
  logic        ALU_enable, LSB_enable;
  logic [3:0]  ALU_RobId, LSB_RobId;
  logic [31:0] ALU_value, LSB_value;
  logic        RS_full, RS_valid;
  logic [5:0]  RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [3:0]  RS_DestRob;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ISS_valid(ISS_valid), .ISS_op(ISS_op), .ISS_Vj(ISS_Vj), .ISS_Vk(ISS_Vk),
    .ISS_Rj(ISS_Rj), .ISS_Rk(ISS_Rk), .ISS_Qj(ISS_Qj), .ISS_Qk(ISS_Qk),
    .ISS_Imm(ISS_Imm), .ISS_DestRob(ISS_DestRob), .ISS_CurPC(ISS_CurPC),
    .ALU_enable(ALU_enable), .ALU_RobId(ALU_RobId), .ALU_value(ALU_value),
    .LSB_enable(LSB_enable), .LSB_RobId(LSB_RobId), .LSB_value(LSB_value),
    .RS_full(RS_full), .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj),
    .RS_Vk(RS_Vk), .RS_Imm(RS_Imm), .RS_DestRob(RS_DestRob), .RS_CurPC(RS_CurPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, imm;
    logic [3:0]  dest;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj;  logic rj; logic [3:0] qj;
    logic [31:0] vk;  logic rk; logic [3:0] qk;
    logic        alu_en; logic [3:0] alu_tag; logic [31:0] alu_val;
    logic        lsb_en; logic [3:0] lsb_tag; logic [31:0] lsb_val;
    logic        disp;
    logic [31:0] exp_vj, exp_vk;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic rdy_at_edge = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic [31:0] imm, input logic [3:0] dest, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.vj = vj; e.vk = vk; e.imm = imm; e.dest = dest; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic rk, input logic [3:0] qk,
                       input logic [31:0] imm, input logic [3:0] dest, input logic [31:0] pc);
    ISS_valid = 1'b1; ISS_op = op; ISS_Vj = vj; ISS_Rj = rj; ISS_Qj = qj;
    ISS_Vk = vk; ISS_Rk = rk; ISS_Qk = qk; ISS_Imm = imm; ISS_DestRob = dest; ISS_CurPC = pc;
  endtask

  task automatic alu(input logic en, input logic [3:0] tag, input logic [31:0] val);
    ALU_enable = en; ALU_RobId = tag; ALU_value = val;
  endtask

  task automatic idle();
    ISS_valid = 1'b0; ALU_enable = 1'b0; LSB_enable = 1'b0;
  endtask

  // Outputs are new only when the preceding edge was enabled.
  always @(posedge clk) rdy_at_edge <= rdy;

  always @(negedge clk) begin
    if (!rst && rdy_at_edge && RS_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dispatch: got op %0h pc %0h expected no dispatch", RS_op, RS_CurPC);
      end else begin
        mon_e = sb.pop_front();
        check("disp_op",   {26'd0, RS_op},      {26'd0, mon_e.op});
        check("disp_vj",   RS_Vj,               mon_e.vj);
        check("disp_vk",   RS_Vk,               mon_e.vk);
        check("disp_imm",  RS_Imm,              mon_e.imm);
        check("disp_dest", {28'd0, RS_DestRob}, {28'd0, mon_e.dest});
        check("disp_pc",   RS_CurPC,            mon_e.pc);
      end
    end
  end

  vec_t vecs[7];

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    ISS_valid = 1'b0; ISS_op = '0; ISS_Vj = '0; ISS_Vk = '0; ISS_Rj = 1'b0; ISS_Rk = 1'b0;
    ISS_Qj = '0; ISS_Qk = '0; ISS_Imm = '0; ISS_DestRob = '0; ISS_CurPC = '0;
    ALU_enable = 1'b0; ALU_RobId = '0; ALU_value = '0;
    LSB_enable = 1'b0; LSB_RobId = '0; LSB_value = '0;

    //          op  vj         rj qj  vk     rk qk  alu           lsb             disp exp_vj   exp_vk
    vecs[0] = '{6'd1, 32'd5,    0, 0, 32'd7, 0, 0, 0, 0, 0,       0, 0, 0,        1, 32'd5,    32'd7};
    vecs[1] = '{6'd2, 32'hdead, 1, 4, 32'd3, 0, 0, 1, 4, 32'h44,  0, 0, 0,        1, 32'h44,   32'd3};
    vecs[2] = '{6'd3, 32'd1,    0, 0, 32'd0, 1, 2, 0, 0, 0,       1, 2, 32'hABCD, 1, 32'd1,    32'hABCD};
    vecs[3] = '{6'd4, 32'd0,    1, 5, 32'd0, 1, 6, 1, 5, 32'h55,  1, 6, 32'h66,   1, 32'h55,   32'h66};
    vecs[4] = '{6'd5, 32'h77,   0, 9, 32'h8, 0, 9, 1, 9, 32'h99,  0, 0, 0,        1, 32'h77,   32'h8};
    vecs[5] = '{6'd6, 32'd0,    1, 10, 32'd0, 1, 10, 1, 10, 32'hA1, 1, 10, 32'hB1, 1, 32'hA1,  32'hA1};
    vecs[6] = '{6'd0, 32'd1,    0, 0, 32'd2, 0, 0, 0, 0, 0,       0, 0, 0,        0, 32'd0,    32'd0};

    tick(); tick();
    check("reset_valid", {31'd0, RS_valid}, 32'd0);
    check("reset_full",  {31'd0, RS_full},  32'd0);
    check("reset_op",    {26'd0, RS_op},    32'd0);
    check("reset_vj",    RS_Vj,             32'd0);
    check("reset_pc",    RS_CurPC,          32'd0);
    rst = 1'b0;
    tick();

    // Single issues with ready or same-cycle-forwarded operands.
    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].op, vecs[v].vj, vecs[v].rj, vecs[v].qj, vecs[v].vk, vecs[v].rk, vecs[v].qk,
            32'h100 + 32'(v), 4'(v), 32'h1000 + 32'(4 * v));
      alu(vecs[v].alu_en, vecs[v].alu_tag, vecs[v].alu_val);
      LSB_enable = vecs[v].lsb_en; LSB_RobId = vecs[v].lsb_tag; LSB_value = vecs[v].lsb_val;
      if (vecs[v].disp)
        push(vecs[v].op, vecs[v].exp_vj, vecs[v].exp_vk, 32'h100 + 32'(v), 4'(v), 32'h1000 + 32'(4 * v));
      tick();
      idle();
      tick();
      check($sformatf("vec%0d_valid", v), {31'd0, RS_valid}, {31'd0, vecs[v].disp});
      tick();
      check($sformatf("vec%0d_drain", v), {31'd0, RS_valid}, 32'd0);
    end

    // Wakeup from a later broadcast dispatches one edge after the wake.
    issue(6'd7, 32'd0, 1, 4'd3, 32'd0, 0, 4'd0, 32'h20, 4'd5, 32'h2000);
    tick();
    alu(1'b1, 4'd3, 32'h10);
    ISS_valid = 1'b0;
    push(6'd7, 32'h10, 32'd0, 32'h20, 4'd5, 32'h2000);
    tick();
    idle();
    check("wake_not_yet", {31'd0, RS_valid}, 32'd0);
    tick();
    check("wake_dispatch", {31'd0, RS_valid}, 32'd1);
    tick();

    // Fill all 16 slots with pending ops, slot k waiting on tag k.
    for (int k = 0; k < 16; k++) begin
      issue(6'(10 + k), 32'd0, 1, 4'(k), 32'(k), 0, 4'd0, 32'(k), 4'(k), 32'h3000 + 32'(4 * k));
      tick();
    end
    idle();
    check("full_after_fill", {31'd0, RS_full}, 32'd1);
    issue(6'd40, 32'd0, 1, 4'd15, 32'd0, 0, 4'd0, 32'h40, 4'd0, 32'h3FFC);
    tick();
    idle();
    check("full_drop_17th", {31'd0, RS_full}, 32'd1);
    alu(1'b1, 4'd9, 32'h109);
    push(6'd19, 32'h109, 32'd9, 32'd9, 4'd9, 32'h3024);
    tick();
    idle();
    check("full_after_wake", {31'd0, RS_full}, 32'd1);
    tick();
    check("full_after_disp9", {31'd0, RS_full}, 32'd0);
    issue(6'd50, 32'd0, 1, 4'd15, 32'h50, 0, 4'd0, 32'h50, 4'd14, 32'h4000);
    tick();
    idle();
    check("full_refill9", {31'd0, RS_full}, 32'd1);
    for (int t = 0; t < 16; t++) begin
      if (t != 9) begin
        alu(1'b1, 4'(t), 32'h100 + 32'(t));
        if (t == 15) push(6'd50, 32'h10F, 32'h50, 32'h50, 4'd14, 32'h4000);
        push(6'(10 + t), 32'h100 + 32'(t), 32'(t), 32'(t), 4'(t), 32'h3000 + 32'(4 * t));
        tick();
      end
    end
    idle();
    tick(); tick(); tick();
    check("drain_not_full", {31'd0, RS_full}, 32'd0);

    // Ready entries in slots 0, 2, 5 among pending ones in 1, 3, 4.
    for (int s = 0; s < 6; s++) begin
      issue(6'(30 + s), 32'd0, 1, (s == 0 || s == 2 || s == 5) ? 4'd7 : 4'd8,
            32'(s), 0, 4'd0, 32'(s), 4'(s), 32'h5000 + 32'(s));
      tick();
    end
    alu(1'b1, 4'd7, 32'h77);
    ISS_valid = 1'b0;
    push(6'd30, 32'h77, 32'd0, 32'd0, 4'd0, 32'h5000);
    push(6'd32, 32'h77, 32'd2, 32'd2, 4'd2, 32'h5002);
    push(6'd35, 32'h77, 32'd5, 32'd5, 4'd5, 32'h5005);
    tick();
    idle();
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("order_valid%0d", n), {31'd0, RS_valid}, 32'd1);
    end
    tick();
    check("order_gap", {31'd0, RS_valid}, 32'd0);

    // Flush with four busy entries and a simultaneous issue.
    issue(6'd36, 32'd0, 1, 4'd8, 32'd0, 0, 4'd0, 32'd0, 4'd6, 32'h5006);
    tick();
    issue(6'd37, 32'd1, 0, 4'd0, 32'd2, 0, 4'd0, 32'd0, 4'd7, 32'h5007);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    check("clear_valid", {31'd0, RS_valid}, 32'd0);
    check("clear_full",  {31'd0, RS_full},  32'd0);
    alu(1'b1, 4'd8, 32'h88);
    tick();
    idle();
    tick(); tick();
    check("clear_no_disp", {31'd0, RS_valid}, 32'd0);

    // Freeze with rdy low while a dispatch is being presented.
    issue(6'd41, 32'd11, 0, 4'd0, 32'd12, 0, 4'd0, 32'd13, 4'd1, 32'h6000);
    push(6'd41, 32'd11, 32'd12, 32'd13, 4'd1, 32'h6000);
    tick();
    issue(6'd42, 32'd21, 0, 4'd0, 32'd22, 0, 4'd0, 32'd23, 4'd2, 32'h6004);
    push(6'd42, 32'd21, 32'd22, 32'd23, 4'd2, 32'h6004);
    tick();
    rdy = 1'b0;
    issue(6'd43, 32'd31, 0, 4'd0, 32'd32, 0, 4'd0, 32'd33, 4'd3, 32'h6008);
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("hold_valid%0d", n), {31'd0, RS_valid}, 32'd1);
      check($sformatf("hold_op%0d", n),    {26'd0, RS_op},    32'd41);
      check($sformatf("hold_vj%0d", n),    RS_Vj,             32'd11);
    end
    rdy = 1'b1;
    idle();
    tick();
    check("resume_op", {26'd0, RS_op}, 32'd42);
    tick();
    check("resume_drain", {31'd0, RS_valid}, 32'd0);
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
